// File: rtl/rr_prio_arbiter4.sv
// Four-requester arbiter with fixed-priority or round-robin selection and a
// hold timeout; registers a one-hot grant plus its encoded index {A,B} and valid Y.
module rr_prio_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       A,
    output logic       B,
    output logic       Y
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nx;
    logic [1:0]       owner, owner_nx;
    logic [1:0]       last, last_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       owner_oh;
    logic [3:0]       cand;
    logic [1:0]       win;
    logic [1:0]       rr_idx;
    logic             grant_new;

    always_comb begin
        owner_oh = 4'b0001 << owner;
        // The current owner never competes against itself; on release req[owner]
        // is already 0, so one masked vector serves release and preemption alike.
        cand = (state == GRANT) ? (req & ~owner_oh) : req;
    end

    always_comb begin
        win    = '0;
        rr_idx = '0;
        if (!mode) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (cand[i]) win = 2'(i);
            end
        end else begin
            // Scan backwards so the first hit after 'last' is the one that sticks.
            for (int unsigned i = 4; i >= 1; i--) begin
                rr_idx = last + 2'(i);
                if (cand[rr_idx]) win = rr_idx;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        last_nx   = last;
        cnt_nx    = cnt;
        grant_new = 1'b0;
        case (state)
            IDLE: begin
                if (|req) grant_new = 1'b1;
            end
            GRANT: begin
                if (!req[owner]) begin
                    if (|cand) begin
                        grant_new = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end else if ((cnt == CNT_MAX) && (|cand)) begin
                    grant_new = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (grant_new) begin
            state_nx = GRANT;
            owner_nx = win;
            last_nx  = win;
            cnt_nx   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            last  <= 2'd3;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        gnt = (state == GRANT) ? owner_oh : '0;
        A   = (state == GRANT) & owner[1];
        B   = (state == GRANT) & owner[0];
        Y   = (state == GRANT);
    end

endmodule

// File: tb/tb_rr_prio_arbiter4.sv
// Scoreboard bench for rr_prio_arbiter4: expected {gnt,A,B,Y} pushed at drive
// time, popped and compared one time unit after the sampling edge.
module tb_rr_prio_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       A, B, Y;

    logic [6:0] sb_q[$];
    logic [6:0] got, want;
    int         n_vec = 0;
    int         n_err = 0;

    rr_prio_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .mode (mode),
        .req  (req),
        .gnt  (gnt),
        .A    (A),
        .B    (B),
        .Y    (Y)
    );

    always #5 clk = ~clk;

    // Expected {gnt, A, B, Y} for owner o; o < 0 means idle.
    function automatic logic [6:0] enc(input int o);
        logic [3:0] oh;
        logic [1:0] ix;
        if (o < 0) return '0;
        ix = 2'(o);
        oh = 4'b0001 << ix;
        return {oh, ix[1], ix[0], 1'b1};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        mode  = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 3) begin
                rst_n = 1'b1;
                req   = 4'b0000;
            end
            sb_q.push_back(enc(-1));
            @(posedge clk); #1;
            got = {gnt, A, B, Y}; want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset[%0d]: got gnt,A,B,Y=%b required %b", i, got, want);
            end
        end
    endtask

    task automatic test_fixed();
        logic [3:0] reqs[3] = '{4'b0101, 4'b0001, 4'b0000};
        int         exp_o[3] = '{2, 0, -1};
        mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req = reqs[i];
            sb_q.push_back(enc(exp_o[i]));
            @(posedge clk); #1;
            got = {gnt, A, B, Y}; want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL fixed[%0d]: got gnt,A,B,Y=%b required %b", i, got, want);
            end
        end
    endtask

    task automatic test_rr_rotation();
        logic [3:0] reqs[11] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101, 4'b1111,
                                 4'b1011, 4'b1111, 4'b0111, 4'b1111, 4'b0000};
        int         exp_o[11] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, -1};
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        #2 rst_n = 1'b1;
        mode = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            req = reqs[i];
            sb_q.push_back(enc(exp_o[i]));
            @(posedge clk); #1;
            got = {gnt, A, B, Y}; want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL rr_rotation[%0d]: got gnt,A,B,Y=%b required %b", i, got, want);
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] r;
        int         e;
        mode = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            if (i == 1)       begin r = 4'b1000; e = 3;  end
            else if (i <= 8)  begin r = 4'b1010; e = 3;  end
            else if (i == 9)  begin r = 4'b1010; e = 1;  end
            else if (i == 10) begin r = 4'b0010; e = 1;  end
            else if (i == 11) begin r = 4'b0000; e = -1; end
            else if (i <= 31) begin r = 4'b1000; e = 3;  end
            else if (i == 32) begin r = 4'b1010; e = 1;  end
            else              begin r = 4'b0000; e = -1; end
            @(negedge clk);
            req = r;
            sb_q.push_back(enc(e));
            @(posedge clk); #1;
            got = {gnt, A, B, Y}; want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL timeout[%0d]: got gnt,A,B,Y=%b required %b", i, got, want);
            end
        end
    endtask

    task automatic test_single_release();
        logic [3:0] reqs[7] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        int         exp_o[7] = '{3, 3, 3, -1, -1, 1, -1};
        mode = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 5) mode = 1'b1;
            req = reqs[i];
            sb_q.push_back(enc(exp_o[i]));
            @(posedge clk); #1;
            got = {gnt, A, B, Y}; want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL single_release[%0d]: got gnt,A,B,Y=%b required %b", i, got, want);
            end
        end
    endtask

    task automatic test_async_reset();
        mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req = 4'b0100;
            sb_q.push_back(enc(2));
            @(posedge clk); #1;
            got = {gnt, A, B, Y}; want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL async_pre[%0d]: got gnt,A,B,Y=%b required %b", i, got, want);
            end
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        sb_q.push_back(enc(-1));
        #1;
        got = {gnt, A, B, Y}; want = sb_q.pop_front(); n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL async_clear: got gnt,A,B,Y=%b required %b", got, want);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rst_n = 1'b1;
                mode  = 1'b1;
            end
            req = (i == 2) ? 4'b0000 : 4'b1111;
            sb_q.push_back(enc((i == 2) ? -1 : 0));
            @(posedge clk); #1;
            got = {gnt, A, B, Y}; want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL async_post[%0d]: got gnt,A,B,Y=%b required %b", i, got, want);
            end
        end
    endtask

    // Independent behavioural model over slowly changing random requests.
    function automatic int pick(input logic [3:0] v, input logic m, input int lst);
        int idx;
        if (!m) begin
            for (int k = 3; k >= 0; k--) if (v[k]) return k;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                idx = (lst + k) % 4;
                if (v[idx]) return idx;
            end
        end
        return -1;
    endfunction

    task automatic test_random();
        int         m_owner = -1;
        int         m_last  = 3;
        int         m_cnt   = 0;
        int         nw;
        logic [3:0] others;
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            nw = -1;
            others = (m_owner >= 0) ? (req & ~(4'b0001 << m_owner)) : req;
            if (m_owner < 0) begin
                if (req != 0) nw = pick(req, mode, m_last);
            end else if (!req[m_owner]) begin
                if (others != 0) nw = pick(others, mode, m_last);
                else m_owner = -1;
            end else if (m_cnt == 7 && others != 0) begin
                nw = pick(others, mode, m_last);
            end else if (m_cnt < 7) begin
                m_cnt++;
            end
            if (nw >= 0) begin
                m_owner = nw;
                m_last  = nw;
                m_cnt   = 0;
            end
            sb_q.push_back(enc(m_owner));
            @(posedge clk); #1;
            got = {gnt, A, B, Y}; want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL random[%0d]: req=%b got gnt,A,B,Y=%b required %b", i, req, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_rotation();
        test_timeout();
        test_single_release();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/rr_prio_arbiter4.md
Name: rr_prio_arbiter4

Overview:
- Sequential 4-requester arbiter sharing one downstream resource, built around the 4-input priority-encoding function (D3 highest).
- Registers a one-hot grant and its encoded index {A,B} with a valid flag Y, in the same encoding the combinational priority encoder produces.
- Supports fixed-priority and round-robin modes, with a hold-timeout that prevents starvation.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles before the owner is preempted when others are waiting; legal range 2..15.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = fixed priority (req[3] highest, req[0] lowest); 1 = round-robin
- req  input  4  request lines; req[i] held high while requester i wants or uses the resource
- gnt  output  4  registered one-hot grant; all zero when idle
- A  output  1  grant index bit 1
- B  output  1  grant index bit 0
- Y  output  1  grant valid; equals |gnt

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, A=0, B=0, Y=0.
  - State=IDLE, hold counter=0, round-robin pointer last=3, so the first RR search starts at 0.
- States:
  - IDLE: no owner. If req!=0, pick a winner per mode and go to GRANT next edge. Latency is 1 cycle: req sampled at edge N gives gnt at edge N.
  - GRANT: owner o holds gnt[o]=1, {A,B}=o, Y=1. The counter increments each cycle in GRANT.
- Release: at an edge where req[o]=0:
  - If other requests are present, grant the winner among req with o masked. New gnt is valid at that same edge, with no idle bubble and counter reset to 0.
  - If no other requests are present, go to IDLE and outputs go to 0.
- Preemption: when req[o]=1, counter==MAX_HOLD-1 and (req & ~onehot(o))!=0, grant the winner among the others at the next edge and reset the counter.
  - If no other request exists, o keeps the grant and the counter saturates at MAX_HOLD-1.
- Winner selection:
  - Fixed mode: highest index set.
  - RR mode: first set bit searching last+1, last+2, … mod 4. last updates to the new owner on every grant in both modes.
- Mode is sampled only at arbitration edges. Changing it during GRANT does not affect the current owner.
- Requests that pulse while another owner holds the grant are not latched; requesters must hold req until granted.
- gnt is always one-hot or zero, never multi-hot; Y=1 iff gnt!=0; {A,B} = 0 when Y=0.
- Reset mid-grant clears everything immediately and asynchronously. The first grant after reset follows reset pointer rules.

Test Plan:
- Reset/idle:
  - Stimulus: rst_n=0 with req=4'b1111, then release rst_n with req=0.
  - Required: gnt=0, Y=0, {A,B}=00 throughout and after.
- Fixed priority:
  - Stimulus: mode=0, req=4'b0101.
  - Required: gnt=4'b0100, {A,B}=10, Y=1 one edge later.
  - Then drop req[2]: gnt=4'b0001, {A,B}=00 at the same edge, no bubble.
- Round-robin rotation:
  - Stimulus: mode=1, req=4'b1111, each owner drops its req for one cycle after 2 grant cycles.
  - Required: grant order 0,1,2,3,0.
- Timeout preemption:
  - Stimulus: mode=0, req[3] held high continuously, req[1] raised at cycle 2.
  - Required: gnt[3] for exactly 8 cycles, then gnt=4'b0010, {A,B}=01.
  - With req[1] absent: gnt[3] held indefinitely.
- Single requester release:
  - Stimulus: req=4'b1000 for 3 cycles, then 0.
  - Required: Y high for 3 cycles, then gnt=0, Y=0, state IDLE.
  - Re-assert req=4'b0010 in RR mode: grant to 1.
- Async reset mid-grant:
  - Stimulus: drop rst_n between clock edges while gnt=4'b0100.
  - Required: outputs clear without waiting for a clock.
  - After release with mode=1, req=4'b1111: first grant is 0.
